multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 170 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32-subset datapath: sequences fetch, decode,
// memory, execute and write-back, with optional memory wait states and a sticky trap.
module multicycle_controller #(
    parameter int MEM_WAIT_EN = 1,
    parameter int ENABLE_JAL  = 1,
    parameter int ALUOP_W     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         Op,
    input  logic               mem_ready,
    output logic               IRWrite,
    output logic               PCUpdate,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               Branch,
    output logic               AdrSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               instr_done,
    output logic               illegal,
    output logic [3:0]         state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t     state_reg;
    state_t     state_next;
    logic       illegal_reg;
    logic       ready;
    logic [1:0] aluop_code;

    // With waits disabled the memory is assumed to answer every cycle.
    assign ready   = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
    assign state_o = state_reg;
    assign illegal = illegal_reg;
    assign ALUOp   = ALUOP_W'(aluop_code);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:    state_next = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (Op == OP_LW || Op == OP_SW)          state_next = S_MEMADR;
                else if (Op == OP_RTYP)                  state_next = S_EXECR;
                else if (Op == OP_ITYP)                  state_next = S_EXECI;
                else if (Op == OP_JAL && ENABLE_JAL != 0) state_next = S_JAL;
                else if (Op == OP_BEQ)                   state_next = S_BEQ;
                else                                     state_next = S_TRAP;
            end
            S_MEMADR:   state_next = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_JAL:      state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            illegal_reg <= illegal_reg | (state_next == S_TRAP);
        end
    end

    // Decoded from the state register; only the handshake strobes also look at
    // mem_ready, so a stalled access never commits.
    always_comb begin
        IRWrite    = 1'b0;
        PCUpdate   = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        Branch     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        aluop_code = 2'b00;
        instr_done = 1'b0;
        if (rst) begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = ready;
                    PCUpdate  = ready;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD: AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc  = 2'b01;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc     = 1'b1;
                    MemWrite   = 1'b1;
                    instr_done = ready;
                end
                S_EXECR: begin
                    ALUSrcA    = 2'b10;
                    aluop_code = 2'b10;
                end
                S_EXECI: begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = 2'b01;
                    aluop_code = 2'b10;
                end
                S_JAL: begin
                    ALUSrcA  = 2'b01;
                    ALUSrcB  = 2'b10;
                    PCUpdate = 1'b1;
                end
                S_ALUWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BEQ: begin
                    ALUSrcA    = 2'b10;
                    aluop_code = 2'b01;
                    Branch     = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller, plus hand-written
// sequences for trap entry/recovery and the JAL-disabled variant.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_ILL  = 7'b1110011;

    // {state, IRWrite,PCUpdate,RegWrite,MemWrite,Branch,AdrSrc, SrcA,SrcB,ResultSrc,ALUOp, done,illegal}
    localparam logic [19:0] E_FETCH_R = {4'd0,  6'b110000, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
    localparam logic [19:0] E_FETCH_S = {4'd0,  6'b000000, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
    localparam logic [19:0] E_DECODE  = {4'd1,  6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    localparam logic [19:0] E_MEMADR  = {4'd2,  6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
    localparam logic [19:0] E_MEMREAD = {4'd3,  6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [19:0] E_MEMWB   = {4'd4,  6'b001000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10};
    localparam logic [19:0] E_MEMW_S  = {4'd5,  6'b000101, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [19:0] E_MEMW_R  = {4'd5,  6'b000101, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [19:0] E_EXECR   = {4'd6,  6'b000000, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00};
    localparam logic [19:0] E_ALUWB   = {4'd7,  6'b001000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [19:0] E_EXECI   = {4'd8,  6'b000000, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00};
    localparam logic [19:0] E_JAL     = {4'd9,  6'b010000, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
    localparam logic [19:0] E_BEQ     = {4'd10, 6'b000010, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10};
    localparam logic [19:0] E_TRAP    = {4'd11, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};

    typedef struct {
        string       name;
        logic        rst;
        logic [6:0]  op;
        logic        rdy;
        logic [19:0] exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [6:0] Op;
    logic       mem_ready;

    logic       IRWrite, PCUpdate, RegWrite, MemWrite, Branch, AdrSrc;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
    logic       instr_done, illegal;
    logic [3:0] state_o;

    logic       IRWrite2, PCUpdate2, RegWrite2, MemWrite2, Branch2, AdrSrc2;
    logic [1:0] ALUSrcA2, ALUSrcB2, ResultSrc2, ALUOp2;
    logic       instr_done2, illegal2;
    logic [3:0] state_o2;

    int   n_cmp;
    int   n_fail;
    vec_t vecs[$];

    multicycle_controller dut (
        .clk(clk), .rst(rst), .Op(Op), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .PCUpdate(PCUpdate), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .Branch(Branch), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ALUOp(ALUOp), .instr_done(instr_done), .illegal(illegal),
        .state_o(state_o)
    );

    multicycle_controller #(.ENABLE_JAL(0)) dut_nojal (
        .clk(clk), .rst(rst), .Op(Op), .mem_ready(mem_ready),
        .IRWrite(IRWrite2), .PCUpdate(PCUpdate2), .RegWrite(RegWrite2),
        .MemWrite(MemWrite2), .Branch(Branch2), .AdrSrc(AdrSrc2),
        .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ResultSrc(ResultSrc2),
        .ALUOp(ALUOp2), .instr_done(instr_done2), .illegal(illegal2),
        .state_o(state_o2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] rst_exp(logic [3:0] st, logic ill);
        return {st, 6'b000000, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, ill};
    endfunction

    function automatic logic [19:0] actual();
        return {state_o, IRWrite, PCUpdate, RegWrite, MemWrite, Branch, AdrSrc,
                ALUSrcA, ALUSrcB, ResultSrc, ALUOp, instr_done, illegal};
    endfunction

    task automatic add(string n, logic r, logic [6:0] o, logic d, logic [19:0] e);
        vec_t v;
        v.name = n; v.rst = r; v.op = o; v.rdy = d; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(string n, logic [19:0] act, logic [19:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h want %05h", n, act, exp);
        end else begin
            $display("ok   %s: %05h", n, act);
        end
    endtask

    // Apply inputs just after a rising edge and stop on the falling edge to sample.
    task automatic drive(logic r, logic [6:0] o, logic d);
        rst = r; Op = o; mem_ready = d;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] rop;
        n_cmp = 0;
        n_fail = 0;

        add("rst",      1, OP_LW,  1, rst_exp(4'd0, 1'b0));
        add("lw_f",     0, OP_LW,  1, E_FETCH_R);
        add("lw_d",     0, OP_LW,  1, E_DECODE);
        add("lw_ma",    0, OP_LW,  1, E_MEMADR);
        add("lw_mr",    0, OP_LW,  1, E_MEMREAD);
        add("lw_wb",    0, OP_LW,  1, E_MEMWB);
        add("sw_f",     0, OP_SW,  1, E_FETCH_R);
        add("sw_d",     0, OP_SW,  1, E_DECODE);
        add("sw_ma",    0, OP_SW,  1, E_MEMADR);
        add("sw_w0",    0, OP_SW,  0, E_MEMW_S);
        add("sw_w1",    0, OP_SW,  0, E_MEMW_S);
        add("sw_w2",    0, OP_SW,  1, E_MEMW_R);
        add("stall0",   0, OP_R,   0, E_FETCH_S);
        add("stall1",   0, OP_R,   0, E_FETCH_S);
        add("stall2",   0, OP_R,   0, E_FETCH_S);
        add("r_f",      0, OP_R,   1, E_FETCH_R);
        add("r_d",      0, OP_R,   1, E_DECODE);
        add("r_ex",     0, OP_ILL, 1, E_EXECR);
        add("r_wb",     0, OP_BEQ, 0, E_ALUWB);
        add("i_f",      0, OP_I,   1, E_FETCH_R);
        add("i_d",      0, OP_I,   1, E_DECODE);
        add("i_ex",     0, OP_I,   1, E_EXECI);
        add("i_wb",     0, OP_I,   1, E_ALUWB);
        add("j_f",      0, OP_JAL, 1, E_FETCH_R);
        add("j_d",      0, OP_JAL, 1, E_DECODE);
        add("j_x",      0, OP_JAL, 1, E_JAL);
        add("j_wb",     0, OP_JAL, 1, E_ALUWB);
        add("b_f",      0, OP_BEQ, 1, E_FETCH_R);
        add("b_d",      0, OP_BEQ, 1, E_DECODE);
        add("b_x",      0, OP_BEQ, 1, E_BEQ);
        add("lr_f",     0, OP_LW,  1, E_FETCH_R);
        add("lr_d",     0, OP_LW,  1, E_DECODE);
        add("lr_ma",    0, OP_LW,  1, E_MEMADR);
        add("lr_w0",    0, OP_LW,  0, E_MEMREAD);
        add("lr_w1",    0, OP_LW,  0, E_MEMREAD);
        add("lr_rst",   1, OP_LW,  0, rst_exp(4'd3, 1'b0));
        add("lr_after", 0, OP_LW,  0, E_FETCH_S);

        rst = 1'b1; Op = OP_LW; mem_ready = 1'b1;
        adv();

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].rdy);
            check(vecs[i].name, actual(), vecs[i].exp);
            adv();
        end

        // Illegal opcode: trap is sticky regardless of inputs until reset.
        drive(0, OP_ILL, 1); check("t_f", actual(), E_FETCH_R); adv();
        drive(0, OP_ILL, 1); check("t_d", actual(), E_DECODE);  adv();
        for (int k = 0; k < 10; k++) begin
            rop = 7'($urandom_range(0, 127));
            drive(0, rop, 1'(k % 2));
            check($sformatf("trap%0d", k), actual(), E_TRAP);
            adv();
        end
        drive(1, OP_ILL, 1); check("t_rst", actual(), rst_exp(4'd11, 1'b1)); adv();
        drive(0, OP_LW, 0);  check("t_after", actual(), E_FETCH_S);        adv();

        // JAL disabled: same opcode stream, second instance must trap.
        drive(0, OP_JAL, 1);
        check("nj_f", 20'({state_o2, illegal2}), 20'({4'd0, 1'b0}));
        adv();
        drive(0, OP_JAL, 1);
        check("nj_d", 20'({state_o2, illegal2}), 20'({4'd1, 1'b0}));
        adv();
        drive(0, OP_JAL, 1);
        check("j2_x", actual(), E_JAL);
        check("nj_trap", 20'({state_o2, illegal2, PCUpdate2}), 20'({4'd11, 1'b1, 1'b0}));
        adv();
        drive(0, OP_JAL, 1);
        check("j2_wb", actual(), E_ALUWB);
        check("nj_hold", 20'({state_o2, illegal2}), 20'({4'd11, 1'b1}));
        adv();
        drive(0, OP_JAL, 1);
        check("j2_back", actual(), E_FETCH_R);
        adv();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
